fp32_dot_accum: RTL and testbench



---
 rtl/fp32_pkg.sv | 30 +++
 rtl/fp32_lzc.sv | 18 +
 rtl/fp32_dot_accum.sv | 216 +++++++++++++++++++++
 tb/tb_fp32_dot_accum.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 constants, word layout and accumulator state encoding for the
// tensor-core accumulate path.
package fp32_pkg;

    localparam int          FP32_BIAS       = 127;
    localparam int          EXP_W           = 8;
    localparam int          FRAC_W          = 23;
    localparam logic [31:0] FP32_QNAN       = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF    = 32'h7F80_0000;
    localparam logic [31:0] FP32_MAX_FINITE = 32'h7F7F_FFFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALIGN    = 2'd1,
        ADD_NORM = 2'd2,
        HOLD     = 2'd3
    } acc_state_t;

    // Significand with hidden bit; exponent 0 is flushed to zero.
    function automatic logic [FRAC_W:0] fp32_sig(input fp32_t v);
        return (v.exp == 8'd0) ? 24'd0 : {1'b1, v.frac};
    endfunction

endpackage

// File: rtl/fp32_lzc.sv
// Combinational leading-zero count; an all-zero input reports W.
module fp32_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  val,
    output logic [CW-1:0] cnt
);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            cnt = val[i] ? CW'(W - 1 - i) : cnt;
        end
    end

endmodule

// File: rtl/fp32_dot_accum.sv
// Sequential FP32 dot-product accumulator, one term per 3 cycles.
// Optional IEEE inf/NaN handling is enabled by defining FP32_DOT_ACCUM_SPECIAL_EN.
module fp32_dot_accum
    import fp32_pkg::*;
#(
    parameter int MAX_TERMS  = 4,
    parameter int GUARD_BITS = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_data,
    input  logic                           in_last,
    input  logic [31:0]                    acc_init,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_data,
    output logic [$clog2(MAX_TERMS+1)-1:0] out_terms
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam int SIG_W = FRAC_W + 1 + GUARD_BITS;
    localparam int LZ_W  = $clog2(SIG_W + 1);

    acc_state_t       state_q, state_d;
    logic [31:0]      acc_q, acc_d, a_q, a_d, b_q, b_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_terms_q, out_terms_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic             big_sign_q, big_sign_d, eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0] big_exp_q, big_exp_d;
    logic [SIG_W-1:0] big_sig_q, big_sig_d, small_sig_q, small_sig_d;

    fp32_t             a_s, b_s, big_s, small_s;
    logic signed [9:0] diff_s, exp_n_s;
    logic [SIG_W-1:0]  small_ext_s, mant_s;
    logic [SIG_W:0]    sum_s;
    logic [LZ_W-1:0]   lz_s;
    logic [31:0]       res_s;
    logic              unused_s;

    // Order operands by magnitude so the subtract path never goes negative.
    always_comb begin
        a_s = a_q;
        b_s = b_q;
        if ({a_s.exp, fp32_sig(a_s)} >= {b_s.exp, fp32_sig(b_s)}) begin
            big_s   = a_s;
            small_s = b_s;
        end else begin
            big_s   = b_s;
            small_s = a_s;
        end
        diff_s      = $signed({2'b00, big_s.exp}) - $signed({2'b00, small_s.exp});
        small_ext_s = {fp32_sig(small_s), {GUARD_BITS{1'b0}}};
        if (diff_s >= 10'(SIG_W)) begin
            small_ext_s = '0;
        end else begin
            small_ext_s = small_ext_s >> diff_s;
        end
    end

    fp32_lzc #(.W(SIG_W)) u_lzc (
        .val (sum_s[SIG_W-1:0]),
        .cnt (lz_s)
    );

    // Add/subtract, normalise, truncate guard bits and resolve range limits.
    always_comb begin
        if (eff_sub_q) begin
            sum_s = {1'b0, big_sig_q} - {1'b0, small_sig_q};
        end else begin
            sum_s = {1'b0, big_sig_q} + {1'b0, small_sig_q};
        end
        if (sum_s[SIG_W]) begin
            mant_s  = sum_s[SIG_W:1];
            exp_n_s = $signed({2'b00, big_exp_q}) + 10'sd1;
        end else begin
            mant_s  = sum_s[SIG_W-1:0] << lz_s;
            exp_n_s = $signed({2'b00, big_exp_q}) - $signed({{(10-LZ_W){1'b0}}, lz_s});
        end
        if (sum_s == '0) begin
            res_s = 32'h0000_0000;
        end else if (exp_n_s <= 10'sd0) begin
            res_s = {big_sign_q, 31'h0000_0000};
        end else if (exp_n_s >= 10'sd255) begin
`ifdef FP32_DOT_ACCUM_SPECIAL_EN
            res_s = {big_sign_q, FP32_POS_INF[30:0]};
`else
            res_s = {big_sign_q, FP32_MAX_FINITE[30:0]};
`endif
        end else begin
            res_s = {big_sign_q, exp_n_s[7:0], mant_s[SIG_W-2 -: FRAC_W]};
        end
`ifdef FP32_DOT_ACCUM_SPECIAL_EN
        // Operands stay latched through ADD_NORM, so specials are decoded here.
        if (((a_s.exp == 8'hFF) && (a_s.frac != 23'd0)) ||
            ((b_s.exp == 8'hFF) && (b_s.frac != 23'd0)) ||
            ((a_s.exp == 8'hFF) && (b_s.exp == 8'hFF) && (a_s.sign != b_s.sign))) begin
            res_s = FP32_QNAN;
        end else if (a_s.exp == 8'hFF) begin
            res_s = a_q;
        end else if (b_s.exp == 8'hFF) begin
            res_s = b_q;
        end else begin
            res_s = res_s;
        end
`endif
    end

    assign unused_s = ^{mant_s[SIG_W-1], mant_s[GUARD_BITS-1:0]};

    // Next-state and datapath register updates.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        big_sign_d  = big_sign_q;
        eff_sub_d   = eff_sub_q;
        big_exp_d   = big_exp_q;
        big_sig_d   = big_sig_q;
        small_sig_d = small_sig_q;
        out_data_d  = out_data_q;
        out_terms_d = out_terms_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = (cnt_q == '0) ? acc_init : acc_q;
                    b_d     = in_data;
                    last_d  = in_last;
                    state_d = ALIGN;
                end else begin
                    state_d = IDLE;
                end
            end
            ALIGN: begin
                big_sign_d  = big_s.sign;
                eff_sub_d   = big_s.sign ^ small_s.sign;
                big_exp_d   = big_s.exp;
                big_sig_d   = {fp32_sig(big_s), {GUARD_BITS{1'b0}}};
                small_sig_d = small_ext_s;
                state_d     = ADD_NORM;
            end
            ADD_NORM: begin
                acc_d = res_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_q || (cnt_d == CNT_W'(MAX_TERMS))) begin
                    out_data_d  = res_s;
                    out_terms_d = cnt_d;
                    state_d     = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    cnt_d   = '0;
                    acc_d   = 32'h0000_0000;
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == HOLD);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 32'h0000_0000;
            cnt_q       <= '0;
            a_q         <= 32'h0000_0000;
            b_q         <= 32'h0000_0000;
            last_q      <= 1'b0;
            big_sign_q  <= 1'b0;
            eff_sub_q   <= 1'b0;
            big_exp_q   <= 8'd0;
            big_sig_q   <= '0;
            small_sig_q <= '0;
            out_data_q  <= 32'h0000_0000;
            out_terms_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            big_sign_q  <= big_sign_d;
            eff_sub_q   <= eff_sub_d;
            big_exp_q   <= big_exp_d;
            big_sig_q   <= big_sig_d;
            small_sig_q <= small_sig_d;
            out_data_q  <= out_data_d;
            out_terms_q <= out_terms_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_terms = out_terms_q;

endmodule

// File: tb/tb_fp32_dot_accum.sv
// Directed self-checking bench for fp32_dot_accum with hand-computed FP32 results.
module tb_fp32_dot_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_last = 1'b0;
    logic [31:0] acc_init = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_terms;

    int checks = 0;
    int errors = 0;

`ifdef FP32_DOT_ACCUM_SPECIAL_EN
    localparam logic [31:0] EXP_OVF_P = 32'h7F80_0000;
    localparam logic [31:0] EXP_OVF_N = 32'hFF80_0000;
    localparam logic [31:0] EXP_E255  = 32'h7FC0_0000;
`else
    localparam logic [31:0] EXP_OVF_P = 32'h7F7F_FFFF;
    localparam logic [31:0] EXP_OVF_N = 32'hFF7F_FFFF;
    localparam logic [31:0] EXP_E255  = 32'h7F7F_FFFF;
`endif

    // Single-term groups: acc_init + in_data.
    localparam logic [31:0] T_INIT [8] = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0001, 32'h80C0_0000,
                                           32'h3F80_0000, 32'h3F80_0003, 32'h4D80_0000, 32'hFF7F_FFFF};
    localparam logic [31:0] T_DATA [8] = '{32'hBF40_0000, 32'hC000_0000, 32'h3F80_0000, 32'h0080_0000,
                                           32'h3380_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hFF7F_FFFF};
    localparam logic [31:0] T_EXP  [8] = '{32'h3E80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h8000_0000,
                                           32'h3F80_0000, 32'h4000_0001, 32'h4D80_0000, EXP_OVF_N};

    fp32_dot_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .acc_init  (acc_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_terms (out_terms)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Waits for in_ready, then performs one input handshake; returns 1 time unit after that edge.
    task automatic send_term(input logic [31:0] d, input logic last, input logic [31:0] init);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready got %b want 1", in_ready);
        end
        in_valid = 1'b1; in_data = d; in_last = last; acc_init = init;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic get_result(output logic [31:0] d, output logic [2:0] t);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL result_timeout out_valid got %b want 1", out_valid);
        end
        d = out_data; t = out_terms;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_terms !== 3'd0) begin errors++; $display("FAIL reset_out_terms got %0d want 0", out_terms); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_four_ones();
        logic [31:0] d; logic [2:0] t;
        for (int i = 0; i < 4; i++) send_term(32'h3F80_0000, (i == 3), 32'h0);
        get_result(d, t);
        checks++; if (d !== 32'h4080_0000) begin errors++; $display("FAIL four_ones_data got %h want 40800000", d); end
        checks++; if (t !== 3'd4) begin errors++; $display("FAIL four_ones_terms got %0d want 4", t); end
    endtask

    task automatic test_cancel_latency();
        logic [31:0] d; logic [2:0] t;
        send_term(32'hC000_0000, 1'b1, 32'h4000_0000);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL lat_edge0 out_valid=%b in_ready=%b want 0 0", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1 out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_edge2 out_valid got %b want 1", out_valid); end
        get_result(d, t);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cancel_data got %h want 00000000", d); end
        checks++; if (t !== 3'd1) begin errors++; $display("FAIL cancel_terms got %0d want 1", t); end
    endtask

    task automatic test_back_pressure();
        int n = 0;
        for (int i = 0; i < 4; i++) send_term(32'h3F80_0000, (i == 3), 32'h0);
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h4080_0000 || out_terms !== 3'd4 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got v=%b d=%h t=%0d rdy=%b want 1 40800000 4 0", c, out_valid, out_data, out_terms, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_release rdy=%b v=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [2:0] t;
        send_term(32'h7F7F_FFFF, 1'b1, 32'h7F7F_FFFF);
        get_result(d, t);
        checks++; if (d !== EXP_OVF_P) begin errors++; $display("FAIL overflow got %h want %h", d, EXP_OVF_P); end
        send_term(32'h0000_0000, 1'b1, 32'h7F80_0001);
        get_result(d, t);
        checks++; if (d !== EXP_E255) begin errors++; $display("FAIL exp255 got %h want %h", d, EXP_E255); end
    endtask

    task automatic test_max_terms();
        logic [31:0] d; logic [2:0] t;
        for (int i = 0; i < 4; i++) send_term(32'h3F80_0000, 1'b0, 32'h0);
        get_result(d, t);
        checks++; if (d !== 32'h4080_0000 || t !== 3'd4) begin errors++; $display("FAIL max_terms got %h/%0d want 40800000/4", d, t); end
        send_term(32'h3F80_0000, 1'b1, 32'h4000_0000);
        get_result(d, t);
        checks++; if (d !== 32'h4040_0000 || t !== 3'd1) begin errors++; $display("FAIL max_next_group got %h/%0d want 40400000/1", d, t); end
    endtask

    task automatic test_reset_mid_group();
        logic [31:0] d; logic [2:0] t;
        send_term(32'h3F80_0000, 1'b0, 32'h40A0_0000);
        send_term(32'h3F80_0000, 1'b0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL midreset v=%b rdy=%b want 0 0", out_valid, in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_release rdy got %b want 1", in_ready); end
        send_term(32'h3F80_0000, 1'b1, 32'h4000_0000);
        get_result(d, t);
        checks++; if (d !== 32'h4040_0000 || t !== 3'd1) begin errors++; $display("FAIL midreset_group got %h/%0d want 40400000/1", d, t); end
    endtask

    task automatic test_arith_table();
        logic [31:0] d; logic [2:0] t;
        for (int i = 0; i < 8; i++) begin
            send_term(T_DATA[i], 1'b1, T_INIT[i]);
            get_result(d, t);
            checks++;
            if (d !== T_EXP[i] || t !== 3'd1) begin
                errors++;
                $display("FAIL arith%0d %h+%h got %h/%0d want %h/1", i, T_INIT[i], T_DATA[i], d, t, T_EXP[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_ones();
        test_cancel_latency();
        test_back_pressure();
        test_overflow();
        test_max_terms();
        test_reset_mid_group();
        test_arith_table();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
